// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared configuration for the weight-fetch engine.
// Default tile geometry and FSM state encoding.
package weight_fetch_ctrl_pkg;

    localparam int ARRAY_N  = 4;
    localparam int DATA_W   = 8;
    localparam int W_ADDR_W = 10;

    typedef enum logic [1:0] {
        WF_IDLE  = 2'd0,
        WF_FETCH = 2'd1,
        WF_DONE  = 2'd2
    } wf_state_e;

endpackage

// File: rtl/weight_fetch_ctrl_outst_cnt.sv
// In-flight read counter with stale-response drop tracking.
// Ports: clk, rst, inc_i (issue), dec_i (response), flush_i (tile abort),
//        outst_o (reads in flight), drop_o (responses still to discard).
module wf_outst_cnt
    import weight_fetch_ctrl_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter int OW        = $clog2(MAX_OUTST + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic          flush_i,
    output logic [OW-1:0] outst_o,
    output logic [OW-1:0] drop_o
);

    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] drop_q, drop_d;
    logic          dec_ok;

    // Saturate at zero so a late response after reset cannot wrap.
    assign dec_ok = dec_i & (outst_q != '0);

    always_comb begin
        outst_d = outst_q;
        if (inc_i & ~dec_ok)
            outst_d = outst_q + 1'b1;
        else if (~inc_i & dec_ok)
            outst_d = outst_q - 1'b1;

        drop_d = drop_q;
        // Everything still in flight at abort belongs to the old tile,
        // except a response consumed in this very cycle.
        if (flush_i)
            drop_d = dec_ok ? outst_q - 1'b1 : outst_q;
        else if (dec_i & (drop_q != '0))
            drop_d = drop_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    assign outst_o = outst_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight-fetch engine: streams ARRAY_N rows from weight memory into the
// systolic array shadow registers and reports w_done when the tile is loaded.
// Ports: clk, rst (sync, active-high); clr_w, w_read, base_addr, w_done
// (controller side); mem_rd_en, mem_addr, mem_rd_valid, mem_rd_data (memory);
// w_load_en, w_load_row, w_load_data (shadow register write port).
module weight_fetch_ctrl
    import weight_fetch_ctrl_pkg::*;
#(
    parameter int ARRAY_N   = weight_fetch_ctrl_pkg::ARRAY_N,
    parameter int DATA_W    = weight_fetch_ctrl_pkg::DATA_W,
    parameter int ADDR_W    = weight_fetch_ctrl_pkg::W_ADDR_W,
    parameter int MAX_OUTST = 4,
    parameter int REVERSE   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_w,
    input  logic                         w_read,
    input  logic [ADDR_W-1:0]            base_addr,
    output logic                         w_done,
    output logic                         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_rd_valid,
    input  logic [ARRAY_N*DATA_W-1:0]    mem_rd_data,
    output logic                         w_load_en,
    output logic [$clog2(ARRAY_N)-1:0]   w_load_row,
    output logic [ARRAY_N*DATA_W-1:0]    w_load_data
);

    localparam int CW = $clog2(ARRAY_N + 1);
    localparam int RW = $clog2(ARRAY_N);
    localparam int OW = $clog2(MAX_OUTST + 1);

    localparam logic [CW-1:0] N_C      = CW'(ARRAY_N);
    localparam logic [OW-1:0] MAX_O    = OW'(MAX_OUTST);
    localparam logic [RW-1:0] LAST_ROW = RW'(ARRAY_N - 1);

    wf_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CW-1:0]       issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]       ret_cnt_q, ret_cnt_d;
    logic                w_done_q, w_done_d;
    logic                ld_en_q;
    logic [RW-1:0]       ld_row_q, ld_row_d;
    logic [ARRAY_N*DATA_W-1:0] ld_data_q;

    logic [OW-1:0]       outst;
    logic [OW-1:0]       drop_cnt;
    logic                fetch;
    logic                issue;
    logic                accept;

    assign fetch = (state_q == WF_FETCH);

    assign issue = fetch & w_read & ~clr_w
                 & (issue_cnt_q < N_C)
                 & (outst < MAX_O);

    // Responses to an aborted tile and the abort-cycle response are discarded.
    assign accept = mem_rd_valid & fetch & ~clr_w
                  & (drop_cnt == '0);

    assign mem_rd_en = issue;
    assign mem_addr  = base_q + ADDR_W'(issue_cnt_q);

    wf_outst_cnt #(
        .MAX_OUTST (MAX_OUTST),
        .OW        (OW)
    ) u_outst (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (issue),
        .dec_i   (mem_rd_valid),
        .flush_i (clr_w),
        .outst_o (outst),
        .drop_o  (drop_cnt)
    );

    always_comb begin
        ld_row_d = ret_cnt_q[RW-1:0];
        if (REVERSE != 0)
            ld_row_d = LAST_ROW - ret_cnt_q[RW-1:0];
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        w_done_d    = w_done_q;
        if (clr_w) begin
            state_d     = WF_FETCH;
            base_d      = base_addr;
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            w_done_d    = 1'b0;
        end else begin
            unique case (state_q)
                WF_FETCH: begin
                    if (issue)
                        issue_cnt_d = issue_cnt_q + 1'b1;
                    if (accept)
                        ret_cnt_d = ret_cnt_q + 1'b1;
                    // ret_cnt counts at capture, so this fires in the
                    // cycle of the final w_load_en.
                    if (ret_cnt_q == N_C) begin
                        state_d  = WF_DONE;
                        w_done_d = 1'b1;
                    end
                end
                WF_DONE: w_done_d = 1'b1;
                default: state_d = WF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WF_IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            w_done_q    <= 1'b0;
            ld_en_q     <= 1'b0;
            ld_row_q    <= '0;
            ld_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            w_done_q    <= w_done_d;
            ld_en_q     <= accept;
            if (accept) begin
                ld_row_q  <= ld_row_d;
                ld_data_q <= mem_rd_data;
            end
        end
    end

    assign w_done      = w_done_q;
    assign w_load_en   = ld_en_q;
    assign w_load_row  = ld_row_q;
    assign w_load_data = ld_data_q;

    a_outst: assert property (@(posedge clk) disable iff (rst)
        outst <= MAX_O);

    a_issue: assert property (@(posedge clk) disable iff (rst)
        issue_cnt_q <= N_C);

    a_load: assert property (@(posedge clk) disable iff (rst)
        accept |-> ret_cnt_q < N_C);

    a_proto: assert property (@(posedge clk) disable iff (rst)
        !(mem_rd_valid && !fetch && drop_cnt == '0));

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Scoreboard bench for weight_fetch_ctrl: two instances (default and
// MAX_OUTST=2/REVERSE=1) each fed by an in-order fixed-latency memory model.
module tb_weight_fetch_ctrl;

    localparam int N = 4;

    typedef struct {
        int         due;
        logic [9:0] a;
    } req_t;

    typedef struct {
        logic [1:0]  row;
        logic [31:0] d;
    } ld_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        clr0, wr0, done0, en0, vld0, ld0;
    logic [9:0]  base0, addr0;
    logic [31:0] rdata0, ldata0;
    logic [1:0]  row0;

    logic        clr1, wr1, done1, en1, vld1, ld1;
    logic [9:0]  base1, addr1;
    logic [31:0] rdata1, ldata1;
    logic [1:0]  row1;

    weight_fetch_ctrl #(
        .ARRAY_N(4), .DATA_W(8), .ADDR_W(10),
        .MAX_OUTST(4), .REVERSE(0)
    ) u0 (
        .clk(clk), .rst(rst), .clr_w(clr0), .w_read(wr0),
        .base_addr(base0), .w_done(done0), .mem_rd_en(en0),
        .mem_addr(addr0), .mem_rd_valid(vld0), .mem_rd_data(rdata0),
        .w_load_en(ld0), .w_load_row(row0), .w_load_data(ldata0)
    );

    weight_fetch_ctrl #(
        .ARRAY_N(4), .DATA_W(8), .ADDR_W(10),
        .MAX_OUTST(2), .REVERSE(1)
    ) u1 (
        .clk(clk), .rst(rst), .clr_w(clr1), .w_read(wr1),
        .base_addr(base1), .w_done(done1), .mem_rd_en(en1),
        .mem_addr(addr1), .mem_rd_valid(vld1), .mem_rd_data(rdata1),
        .w_load_en(ld1), .w_load_row(row1), .w_load_data(ldata1)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    int lat0   = 2;
    int lat1   = 3;
    int loads0 = 0;
    int loads1 = 0;
    int max1   = 0;
    int rises1 = 0;
    int ti, td;
    logic pd1 = 1'b0;

    req_t       mq0[$], mq1[$];
    logic [9:0] ea0[$], ea1[$];
    ld_t        el0[$], el1[$];
    ld_t        e0, e1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mdata(input logic [9:0] a);
        return {6'h2A, a, 16'hBEEF ^ {6'h0, a}};
    endfunction

    always @(negedge clk) begin
        vld0 = 1'b0;
        rdata0 = '0;
        if (rst) begin
            mq0.delete();
        end else begin
            if (mq0.size() > 0 && mq0[0].due == cyc) begin
                vld0 = 1'b1;
                rdata0 = mdata(mq0[0].a);
                void'(mq0.pop_front());
            end
            if (en0) begin
                mq0.push_back('{cyc + lat0, addr0});
                if (ea0.size() == 0)
                    chk("addr0_extra", 32'(ea0.size()), 1);
                else
                    chk("addr0", 32'(addr0), 32'(ea0.pop_front()));
            end
            if (ld0) begin
                loads0++;
                if (el0.size() == 0) begin
                    chk("load0_extra", 32'(el0.size()), 1);
                end else begin
                    e0 = el0.pop_front();
                    chk("row0", 32'(row0), 32'(e0.row));
                    chk("data0", ldata0, e0.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        vld1 = 1'b0;
        rdata1 = '0;
        if (done1 && !pd1)
            rises1++;
        pd1 = done1;
        if (rst) begin
            mq1.delete();
        end else begin
            if (mq1.size() > 0 && mq1[0].due == cyc) begin
                vld1 = 1'b1;
                rdata1 = mdata(mq1[0].a);
                void'(mq1.pop_front());
            end
            if (en1) begin
                mq1.push_back('{cyc + lat1, addr1});
                if (mq1.size() > max1)
                    max1 = mq1.size();
                if (ea1.size() == 0)
                    chk("addr1_extra", 32'(ea1.size()), 1);
                else
                    chk("addr1", 32'(addr1), 32'(ea1.pop_front()));
            end
            if (ld1) begin
                loads1++;
                if (el1.size() == 0) begin
                    chk("load1_extra", 32'(el1.size()), 1);
                end else begin
                    e1 = el1.pop_front();
                    chk("row1", 32'(row1), 32'(e1.row));
                    chk("data1", ldata1, e1.d);
                end
            end
        end
    end

    // Called just after a posedge; holds clr_w for exactly one cycle.
    task automatic start0(input logic [9:0] b);
        logic [9:0] a;
        clr0 = 1'b1;
        base0 = b;
        ea0.delete();
        el0.delete();
        loads0 = 0;
        for (int i = 0; i < N; i++) begin
            a = b + 10'(i);
            ea0.push_back(a);
            el0.push_back('{2'(i), mdata(a)});
        end
        @(posedge clk);
        #1;
        clr0 = 1'b0;
    endtask

    task automatic start1(input logic [9:0] b);
        logic [9:0] a;
        clr1 = 1'b1;
        base1 = b;
        ea1.delete();
        el1.delete();
        loads1 = 0;
        for (int i = 0; i < N; i++) begin
            a = b + 10'(i);
            ea1.push_back(a);
            el1.push_back('{2'(N - 1 - i), mdata(a)});
        end
        @(posedge clk);
        #1;
        clr1 = 1'b0;
    endtask

    task automatic wait_done0(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done0)
                break;
        end
        chk(tag, 32'(done0), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clr0 = 1'b0; wr0 = 1'b0; base0 = '0;
        clr1 = 1'b0; wr1 = 1'b0; base1 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_done0", 32'(done0), 0);
        chk("rst_rden0", 32'(en0), 0);
        chk("rst_load0", 32'(ld0), 0);
        chk("rst_ldata0", ldata0, 0);
        chk("rst_done1", 32'(done1), 0);
        chk("rst_load1", 32'(ld1), 0);

        // Straight tile, latency 2: w_done at first issue + 7.
        @(posedge clk);
        #1;
        lat0 = 2;
        wr0 = 1'b1;
        start0(10'h010);
        ti = -100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (en0) begin
                ti = cyc;
                break;
            end
        end
        wait_done0("t1_done");
        td = cyc;
        chk("t1_latency", 32'(td - ti), 7);
        chk("t1_loads", 32'(loads0), 4);
        repeat (3) @(negedge clk);
        chk("t1_done_held", 32'(done0), 1);

        // Abort after two issues, no returns: stale rows must vanish.
        @(posedge clk);
        #1;
        lat0 = 3;
        start0(10'h200);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start0(10'h100);
        wait_done0("t3_done");
        chk("t3_loads", 32'(loads0), 4);
        chk("t3_addr_left", 32'(ea0.size()), 0);
        repeat (5) @(negedge clk);
        chk("t3_no_late_load", 32'(loads0), 4);

        // Address wrap at the top of memory.
        @(posedge clk);
        #1;
        lat0 = 1;
        start0(10'h3FE);
        wait_done0("t5_done");
        chk("t5_loads", 32'(loads0), 4);
        chk("t5_addr_left", 32'(ea0.size()), 0);

        // Back-to-back tiles restarted straight from DONE.
        @(posedge clk);
        #1;
        lat0 = 2;
        start0(10'h050);
        @(negedge clk);
        chk("t6_done_low_a", 32'(done0), 0);
        wait_done0("t6_done_a");
        chk("t6_loads_a", 32'(loads0), 4);
        @(posedge clk);
        #1;
        start0(10'h060);
        @(negedge clk);
        chk("t6_done_low_b", 32'(done0), 0);
        wait_done0("t6_done_b");
        chk("t6_loads_b", 32'(loads0), 4);
        chk("t6_rows_left", 32'(el0.size()), 0);

        // Toggling w_read, latency 3, two in flight, bottom-up rows.
        @(posedge clk);
        #1;
        lat1 = 3;
        wr1 = 1'b1;
        start1(10'h020);
        for (int i = 0; i < 60; i++) begin
            wr1 = ~wr1;
            @(posedge clk);
            #1;
        end
        chk("t2_done", 32'(done1), 1);
        chk("t2_done_rises", 32'(rises1), 1);
        chk("t2_max_outst", 32'(max1 <= 2), 1);
        chk("t2_loads", 32'(loads1), 4);
        chk("t2_rows_left", 32'(el1.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
